midi_msg_parser: RTL and testbench

- Decodes the MIDI receiver's byte stream (byteready_u, cur_status_u, midibyte_nr_u, midi_in_data_u) into complete channel-voice events.
- Sits directly downstream of the MIDI UART and upstream of voice allocation and the controller map.
- Handles running status, note-on with velocity 0 and an optional channel filter.
- Buffers decoded events in a small FIFO with a valid/ready handshake.

---
 rtl/midi_msg_parser.sv | 197 +++++++++++++++++++
 tb/tb_midi_msg_parser.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/midi_msg_parser.sv
// rtl/midi_msg_parser.sv - MIDI channel-voice message parser with event FIFO
//
// Samples the MIDI receiver's status/count/data inputs a fixed SETTLE cycles
// after each byteready_u rising edge, assembles channel-voice messages
// (running status, note-on velocity 0 as note-off, optional channel filter)
// and queues complete events in a show-ahead FIFO.
//
// Ports:
//   reg_clk, reset_reg_N          clock, asynchronous active-low reset
//   byteready_u                   receiver byte strobe (level, long high)
//   cur_status_u, midibyte_nr_u   last status byte, data bytes since status
//   midi_in_data_u                last received byte
//   omni, rx_chan                 channel filter (omni=1 accepts all)
//   ev_valid/ev_ready             event handshake, ev_* hold the FIFO head
//   ev_type, ev_chan, ev_d1, ev_d2 decoded event fields
//   fifo_level                    occupied FIFO entries
//   overflow, overflow_clr        sticky drop flag and its clear
module midi_msg_parser #(
  parameter int SETTLE     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          reg_clk,
  input  logic                          reset_reg_N,
  input  logic                          byteready_u,
  input  logic [7:0]                    cur_status_u,
  input  logic [7:0]                    midibyte_nr_u,
  input  logic [7:0]                    midi_in_data_u,
  input  logic                          omni,
  input  logic [3:0]                    rx_chan,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [2:0]                    ev_type,
  output logic [3:0]                    ev_chan,
  output logic [6:0]                    ev_d1,
  output logic [6:0]                    ev_d2,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          overflow_clr
);

  localparam int         AW       = $clog2(FIFO_DEPTH);
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DECODE} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        byteready_q;
  logic        rise;
  logic        capture;
  logic [7:0]  s_q, n_q, d_q;
  logic        have_d1, have_d1_nx;
  logic [6:0]  d1_reg, d1_reg_nx;

  logic        emit, push;
  logic [2:0]  pkt_type;
  logic [6:0]  pkt_d1, pkt_d2;

  assign rise = byteready_u & ~byteready_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state       <= IDLE;
      cnt         <= '0;
      byteready_q <= 1'b0;
      s_q         <= '0;
      n_q         <= '0;
      d_q         <= '0;
      have_d1     <= 1'b0;
      d1_reg      <= '0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      byteready_q <= byteready_u;
      have_d1     <= have_d1_nx;
      d1_reg      <= d1_reg_nx;
      if (capture) begin
        s_q <= cur_status_u;
        n_q <= midibyte_nr_u;
        d_q <= midi_in_data_u;
      end
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          cnt_nx   = CNT_LOAD;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        // A fresh strobe while settling restarts the settle window.
        if (rise) begin
          cnt_nx = CNT_LOAD;
        end else if (cnt == 4'd0) begin
          capture  = 1'b1;
          state_nx = DECODE;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      DECODE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ------------------------------------------------------------- decode
  always_comb begin
    emit       = 1'b0;
    pkt_type   = 3'd0;
    pkt_d1     = '0;
    pkt_d2     = '0;
    have_d1_nx = have_d1;
    d1_reg_nx  = d1_reg;
    if (state == DECODE) begin
      if (d_q[7] || !s_q[7] || s_q[7:4] == 4'hF) begin
        // Status bytes and data under system/no status break pairing.
        have_d1_nx = 1'b0;
      end else if (s_q[7:4] == 4'hC || s_q[7:4] == 4'hD) begin
        emit     = 1'b1;
        pkt_type = (s_q[7:4] == 4'hC) ? 3'd4 : 3'd5;
        pkt_d1   = d_q[6:0];
      end else if (n_q == 8'd1 || !have_d1) begin
        // First data byte of a pair; N==1 always restarts the pair so a
        // stale half-message cannot mis-align running status.
        d1_reg_nx  = d_q[6:0];
        have_d1_nx = 1'b1;
      end else begin
        emit       = 1'b1;
        pkt_d1     = d1_reg;
        pkt_d2     = d_q[6:0];
        have_d1_nx = 1'b0;
        case (s_q[7:4])
          4'h8:    pkt_type = 3'd0;
          4'h9:    pkt_type = (d_q[6:0] == 7'd0) ? 3'd0 : 3'd1;
          4'hA:    pkt_type = 3'd2;
          4'hB:    pkt_type = 3'd3;
          default: pkt_type = 3'd6;
        endcase
      end
    end
  end

  assign push = emit & (omni | (s_q[3:0] == rx_chan));

  // --------------------------------------------------------------- FIFO
  logic [20:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level;
  logic          full, pop, wr_en, drop;
  logic [20:0]   head;

  assign full     = (level == (AW+1)'(FIFO_DEPTH));
  assign ev_valid = (level != '0);
  assign pop      = ev_valid & ev_ready;
  assign wr_en    = push & (~full | pop);
  assign drop     = push & full & ~pop;

  always_ff @(posedge reg_clk) begin
    if (wr_en) mem[wr_ptr] <= {pkt_type, s_q[3:0], pkt_d1, pkt_d2};
  end

  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  // Fields read zero while empty so outputs match their reset values.
  assign head       = ev_valid ? mem[rd_ptr] : '0;
  assign ev_type    = head[20:18];
  assign ev_chan    = head[17:14];
  assign ev_d1      = head[13:7];
  assign ev_d2      = head[6:0];
  assign fifo_level = level;

endmodule

// File: tb/tb_midi_msg_parser.sv
// tb/tb_midi_msg_parser.sv - directed self-checking bench for midi_msg_parser
module tb_midi_msg_parser;

  localparam int SETTLE     = 4;
  localparam int FIFO_DEPTH = 4;

  logic        reg_clk = 1'b0;
  logic        reset_reg_N;
  logic        byteready_u;
  logic [7:0]  cur_status_u, midibyte_nr_u, midi_in_data_u;
  logic        omni;
  logic [3:0]  rx_chan;
  logic        ev_valid, ev_ready;
  logic [2:0]  ev_type;
  logic [3:0]  ev_chan;
  logic [6:0]  ev_d1, ev_d2;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic        overflow, overflow_clr;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] cur_st = 8'h00;
  logic [7:0] nr     = 8'h00;

  always #5 reg_clk = ~reg_clk;

  midi_msg_parser #(.SETTLE(SETTLE), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .reg_clk(reg_clk), .reset_reg_N(reset_reg_N), .byteready_u(byteready_u),
    .cur_status_u(cur_status_u), .midibyte_nr_u(midibyte_nr_u),
    .midi_in_data_u(midi_in_data_u), .omni(omni), .rx_chan(rx_chan),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_type(ev_type),
    .ev_chan(ev_chan), .ev_d1(ev_d1), .ev_d2(ev_d2),
    .fifo_level(fifo_level), .overflow(overflow), .overflow_clr(overflow_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Drives the receiver outputs the way the UART would for byte b.
  task automatic prep(input logic [7:0] b);
    if (b[7]) begin
      cur_st = b;
      nr     = 8'h00;
    end else begin
      nr = nr + 8'h01;
    end
    cur_status_u   = cur_st;
    midibyte_nr_u  = nr;
    midi_in_data_u = b;
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge reg_clk);
    prep(b);
    byteready_u = 1'b1;
    repeat (SETTLE + 4) @(negedge reg_clk);
    byteready_u = 1'b0;
    repeat (3) @(negedge reg_clk);
  endtask

  task automatic expect_ev(input string tag, input logic [2:0] t, input logic [3:0] c,
                           input logic [6:0] d1, input logic [6:0] d2);
    int n = 0;
    while (!ev_valid && n < 100) begin
      @(negedge reg_clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(ev_valid), 32'd1);
    if (ev_valid) begin
      chk({tag, "_type"}, 32'(ev_type), 32'(t));
      chk({tag, "_chan"}, 32'(ev_chan), 32'(c));
      chk({tag, "_d1"},   32'(ev_d1),   32'(d1));
      chk({tag, "_d2"},   32'(ev_d2),   32'(d2));
      ev_ready = 1'b1;
      @(negedge reg_clk);
      ev_ready = 1'b0;
    end
  endtask

  initial begin
    reset_reg_N    = 1'b0;
    byteready_u    = 1'b0;
    cur_status_u   = '0;
    midibyte_nr_u  = '0;
    midi_in_data_u = '0;
    omni           = 1'b1;
    rx_chan        = 4'd0;
    ev_ready       = 1'b0;
    overflow_clr   = 1'b0;
    repeat (3) @(negedge reg_clk);
    chk("rst_valid",    32'(ev_valid),   32'd0);
    chk("rst_type",     32'(ev_type),    32'd0);
    chk("rst_chan",     32'(ev_chan),    32'd0);
    chk("rst_d1",       32'(ev_d1),      32'd0);
    chk("rst_d2",       32'(ev_d2),      32'd0);
    chk("rst_level",    32'(fifo_level), 32'd0);
    chk("rst_overflow", 32'(overflow),   32'd0);
    reset_reg_N = 1'b1;
    repeat (2) @(negedge reg_clk);

    // Note-on with latency measurement on the final byte.
    send(8'h90);
    send(8'h3C);
    @(negedge reg_clk);
    prep(8'h64);
    byteready_u = 1'b1;
    @(posedge reg_clk);                   // rise seen here
    repeat (SETTLE) @(posedge reg_clk);   // capture edge
    @(negedge reg_clk);
    chk("lat_early", 32'(ev_valid), 32'd0);
    @(posedge reg_clk);                   // push edge
    @(negedge reg_clk);
    chk("lat_on", 32'(ev_valid), 32'd1);
    repeat (3) @(negedge reg_clk);
    byteready_u = 1'b0;
    repeat (3) @(negedge reg_clk);
    expect_ev("non", 3'd1, 4'd0, 7'h3C, 7'h64);

    // Running status, velocity 0 becomes note-off.
    send(8'h91); send(8'h40); send(8'h7F); send(8'h40); send(8'h00);
    expect_ev("rs_on",  3'd1, 4'd1, 7'h40, 7'h7F);
    expect_ev("rs_off", 3'd0, 4'd1, 7'h40, 7'h00);

    // Pitch bend, program change, channel pressure.
    send(8'hE2); send(8'h00); send(8'h40);
    send(8'hC5); send(8'h07);
    send(8'hD5); send(8'h20);
    chk("mix_level", 32'(fifo_level), 32'd3);
    expect_ev("pb", 3'd6, 4'd2, 7'h00, 7'h40);
    expect_ev("pc", 3'd4, 4'd5, 7'h07, 7'h00);
    expect_ev("cp", 3'd5, 4'd5, 7'h20, 7'h00);

    // Channel filter.
    omni = 1'b0;
    rx_chan = 4'd3;
    send(8'hB2); send(8'h07); send(8'h64);
    send(8'hB3); send(8'h07); send(8'h64);
    chk("filt_level", 32'(fifo_level), 32'd1);
    expect_ev("filt_cc", 3'd3, 4'd3, 7'h07, 7'h64);
    omni = 1'b1;

    // Overflow: five note-ons into a four-entry FIFO.
    send(8'h90); send(8'h3C); send(8'h64);
    send(8'h3D); send(8'h64);
    send(8'h3E); send(8'h64);
    send(8'h3F); send(8'h64);
    send(8'h40); send(8'h64);
    chk("ovf_level", 32'(fifo_level), 32'd4);
    chk("ovf_flag",  32'(overflow),   32'd1);
    expect_ev("drain0", 3'd1, 4'd0, 7'h3C, 7'h64);
    expect_ev("drain1", 3'd1, 4'd0, 7'h3D, 7'h64);
    expect_ev("drain2", 3'd1, 4'd0, 7'h3E, 7'h64);
    expect_ev("drain3", 3'd1, 4'd0, 7'h3F, 7'h64);
    repeat (3) @(negedge reg_clk);
    chk("drain_empty", 32'(ev_valid),   32'd0);
    chk("drain_level", 32'(fifo_level), 32'd0);
    chk("ovf_sticky",  32'(overflow),   32'd1);
    overflow_clr = 1'b1;
    @(negedge reg_clk);
    overflow_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Reset in the middle of a message and of a pending capture.
    send(8'h90); send(8'h3C);
    @(negedge reg_clk);
    prep(8'h64);
    byteready_u = 1'b1;
    repeat (2) @(negedge reg_clk);
    reset_reg_N = 1'b0;
    byteready_u = 1'b0;
    repeat (2) @(negedge reg_clk);
    reset_reg_N = 1'b1;
    repeat (SETTLE + 6) @(negedge reg_clk);
    chk("abort_level", 32'(fifo_level), 32'd0);
    send(8'h90); send(8'h3C); send(8'h64);
    chk("resync_level", 32'(fifo_level), 32'd1);
    expect_ev("resync", 3'd1, 4'd0, 7'h3C, 7'h64);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
